// File: rtl/uart_pkg.sv
// Shared state type, oversampling constants and the majority-vote helper
// used by the UART receive path.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);

  localparam logic [CNT_W-1:0] SAMPLE_A  = CNT_W'(7);
  localparam logic [CNT_W-1:0] SAMPLE_B  = CNT_W'(8);
  localparam logic [CNT_W-1:0] SAMPLE_C  = CNT_W'(9);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs; resets to all ones
// so an idle-high line does not look active coming out of reset.
module uart_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, majority-voted bit sampling with start-bit
// glitch rejection and a valid/ready holding register for the deframed word.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned      IDX_W      = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_ODD    = 1'(PARITY_ODD);
  localparam rx_state_t        AFTER_DATA = (PARITY_EN != 0) ? PARITY : STOP;

  logic                 w_rx_s;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_s7;
  logic                 r_s8;
  logic                 w_maj;
  logic                 w_decide;
  logic                 w_last;
  logic                 w_shift_en;
  logic                 w_par_en;
  logic                 w_done;
  logic                 r_par_err;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;
  logic                 r_busy;

  uart_sync2 #(.WIDTH(1)) u_sync (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_d     (rx_i),
    .o_q     (w_rx_s)
  );

  // Third sample comes straight from the synchroniser on the deciding tick.
  assign w_maj    = majority3(r_s7, r_s8, w_rx_s);
  assign w_decide = tick_i && (r_cnt == SAMPLE_C);
  assign w_last   = tick_i && (r_cnt == LAST_TICK);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (tick_i && !w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (w_decide && w_maj) w_state_nxt = IDLE;
        else if (w_last)       w_state_nxt = DATA;
      end
      DATA: begin
        w_shift_en = w_decide;
        if (w_last && (r_bit_idx == LAST_IDX)) w_state_nxt = AFTER_DATA;
      end
      PARITY: begin
        w_par_en = w_decide;
        if (w_last) w_state_nxt = STOP;
      end
      // Leaving at mid-stop-bit gives half a bit of slack for baud mismatch.
      STOP: begin
        w_done = w_decide;
        if (w_decide) w_state_nxt = w_maj ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
      r_s7  <= 1'b1;
      r_s8  <= 1'b1;
    end else begin
      if ((r_state == IDLE) || (w_state_nxt == IDLE)) r_cnt <= '0;
      else if (tick_i)                                 r_cnt <= r_cnt + CNT_W'(1);
      if (tick_i && (r_cnt == SAMPLE_A)) r_s7 <= w_rx_s;
      if (tick_i && (r_cnt == SAMPLE_B)) r_s8 <= w_rx_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
    end else begin
      if (r_state != DATA) r_bit_idx <= '0;
      else if (w_last)     r_bit_idx <= r_bit_idx + IDX_W'(1);
      if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      if (r_state == START) r_par_err <= 1'b0;
      else if (w_par_en)    r_par_err <= (^r_shift) ^ w_maj ^ PAR_ODD;
    end
  end

  // Holding register: a word completing while the previous one is still
  // unaccepted is dropped and reported as an overrun.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_busy    <= (w_state_nxt != IDLE);
      if (w_done) begin
        if (!r_valid || ready_i) begin
          r_data       <= r_shift;
          r_frame_err  <= !w_maj;
          r_parity_err <= r_par_err;
          r_valid      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign frame_err_o  = r_frame_err;
  assign parity_err_o = r_parity_err;
  assign overrun_o    = r_overrun;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance share the
// serial line, clock, tick and reset.
module tb_uart_rx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b1;
  logic       ready_p = 1'b1;
  logic [1:0] div   = 2'd0;

  logic [7:0] data;
  logic       valid, fe, pe, ovr, busy;
  logic [7:0] data_p;
  logic       valid_p, fe_p, pe_p, ovr_p, busy_p;

  int total = 0;
  int bad   = 0;

  int         n_vld   = 0;
  int         n_ovr   = 0;
  int         n_vld_p = 0;
  logic [7:0] cap_data   = 8'h00;
  logic       cap_fe     = 1'b0;
  logic       cap_pe     = 1'b0;
  logic [7:0] cap_data_p = 8'h00;
  logic       cap_pe_p   = 1'b0;

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .tick_i(tick), .rx_i(rx),
    .data_o(data), .valid_o(valid), .ready_i(ready),
    .frame_err_o(fe), .parity_err_o(pe), .overrun_o(ovr), .busy_o(busy)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
    .clk_i(clk), .rst_n_i(rst_n), .tick_i(tick), .rx_i(rx),
    .data_o(data_p), .valid_o(valid_p), .ready_i(ready_p),
    .frame_err_o(fe_p), .parity_err_o(pe_p), .overrun_o(ovr_p), .busy_o(busy_p)
  );

  always #5 clk = ~clk;

  // One-cycle tick every 4 clocks, changed on the falling edge.
  always @(negedge clk) begin
    div  = div + 2'd1;
    tick = (div == 2'd0);
  end

  always @(negedge clk) begin
    if (valid) begin
      n_vld++;
      cap_data = data;
      cap_fe   = fe;
      cap_pe   = pe;
    end
    if (ovr) n_ovr++;
    if (valid_p) begin
      n_vld_p++;
      cap_data_p = data_p;
      cap_pe_p   = pe_p;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par, input logic pbit,
                            input logic stop);
    wait_ticks(1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({data, valid, fe, pe, ovr, busy} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {data, valid, fe, pe, ovr, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_basic();
    int v0;
    v0 = n_vld;
    ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    @(negedge clk);
    total++;
    if (n_vld - v0 != 1) begin
      bad++; $display("FAIL basic_valid_cycles got=%0d exp=1", n_vld - v0);
    end
    total++;
    if (cap_data !== 8'hA5) begin
      bad++; $display("FAIL basic_data got=%h exp=a5", cap_data);
    end
    total++;
    if ({cap_fe, cap_pe} !== 2'b00) begin
      bad++; $display("FAIL basic_flags got=%b exp=00", {cap_fe, cap_pe});
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL basic_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = n_vld;
    wait_ticks(1);
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(5);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(16);
    @(negedge clk);
    total++;
    if ((n_vld != v0) || (busy !== 1'b0)) begin
      bad++; $display("FAIL glitch_reject got=%0d/%b exp=0/0", n_vld - v0, busy);
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    @(negedge clk);
    total++;
    if ((n_vld - v0 != 1) || (cap_data !== 8'h3C)) begin
      bad++; $display("FAIL glitch_next_frame got=%0d/%h exp=1/3c", n_vld - v0, cap_data);
    end
  endtask

  // Line pulled high only for the middle sample of bit 3.
  task automatic test_noise();
    int v0;
    v0 = n_vld;
    wait_ticks(1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    @(negedge clk); rx = 1'b0; wait_ticks(9);
    @(negedge clk); rx = 1'b1; wait_ticks(1);
    @(negedge clk); rx = 1'b0; wait_ticks(6);
    for (int i = 4; i < 8; i++) send_bit(1'b0);
    send_bit(1'b1);
    wait_ticks(2);
    @(negedge clk);
    total++;
    if ((n_vld - v0 != 1) || (cap_data !== 8'h00) || (cap_fe !== 1'b0)) begin
      bad++; $display("FAIL noise_majority got=%0d/%h/%b exp=1/00/0", n_vld - v0, cap_data, cap_fe);
    end
  endtask

  task automatic test_parity();
    int v0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    ready_p = 1'b1;
    wait_ticks(4);
    v0 = n_vld_p;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_ticks(2);
    @(negedge clk);
    total++;
    if ((n_vld_p - v0 != 1) || (cap_data_p !== 8'h07) || (cap_pe_p !== 1'b0)) begin
      bad++; $display("FAIL parity_good got=%0d/%h/%b exp=1/07/0", n_vld_p - v0, cap_data_p, cap_pe_p);
    end
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    wait_ticks(2);
    @(negedge clk);
    total++;
    if ((n_vld_p - v0 != 2) || (cap_data_p !== 8'h07) || (cap_pe_p !== 1'b1)) begin
      bad++; $display("FAIL parity_bad got=%0d/%h/%b exp=2/07/1", n_vld_p - v0, cap_data_p, cap_pe_p);
    end
    wait_ticks(20);
  endtask

  task automatic test_framing();
    int v0;
    v0 = n_vld;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_ticks(32);
    @(negedge clk);
    total++;
    if ((n_vld - v0 != 1) || (cap_data !== 8'h55) || (cap_fe !== 1'b1)) begin
      bad++; $display("FAIL frame_err got=%0d/%h/%b exp=1/55/1", n_vld - v0, cap_data, cap_fe);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL wait_high_busy got=%b exp=1", busy);
    end
    rx = 1'b1;
    wait_ticks(2);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL wait_high_release got=%b exp=0", busy);
    end
  endtask

  task automatic test_break();
    int v0;
    v0 = n_vld;
    wait_ticks(1);
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(16 * 20);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(32);
    @(negedge clk);
    total++;
    if ((n_vld - v0 != 1) || (cap_data !== 8'h00) || (cap_fe !== 1'b1) || (busy !== 1'b0)) begin
      bad++; $display("FAIL break_word got=%0d/%h/%b/%b exp=1/00/1/0", n_vld - v0, cap_data, cap_fe, busy);
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    o0 = n_ovr;
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    total++;
    if ((valid !== 1'b1) || (data !== 8'h11)) begin
      bad++; $display("FAIL overrun_keep got=%b/%h exp=1/11", valid, data);
    end
    total++;
    if (n_ovr - o0 != 1) begin
      bad++; $display("FAIL overrun_pulse got=%0d exp=1", n_ovr - o0);
    end
    ready = 1'b1;
    @(negedge clk);
    total++;
    if ((valid !== 1'b0) || (data !== 8'h11)) begin
      bad++; $display("FAIL handshake_clear got=%b/%h exp=0/11", valid, data);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    wait_ticks(1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    total++;
    if ({data, valid, fe, pe, ovr, busy} !== 13'h0) begin
      bad++; $display("FAIL reset_mid_outputs got=%h exp=0", {data, valid, fe, pe, ovr, busy});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    v0 = n_vld;
    wait_ticks(160);
    @(negedge clk);
    total++;
    if ((n_vld != v0) || (busy !== 1'b0)) begin
      bad++; $display("FAIL reset_no_partial got=%0d/%b exp=0/0", n_vld - v0, busy);
    end
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    wait_ticks(2);
    @(negedge clk);
    total++;
    if ((n_vld - v0 != 1) || (cap_data !== 8'hC3) || (cap_fe !== 1'b0)) begin
      bad++; $display("FAIL reset_next_frame got=%0d/%h/%b exp=1/c3/0", n_vld - v0, cap_data, cap_fe);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_noise();
    test_parity();
    test_framing();
    test_break();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that consumes the oversampling tick from the baud tick generator. The tick arrives at 16 ticks per bit period for every rate setting. The block synchronises the serial line, detects start bits with glitch rejection, and samples each bit by majority vote. It delivers the deframed word through a valid/ready holding register, flagging framing, parity and overrun errors to the downstream UART/CORDIC control logic.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), received LSB first
PARITY_EN, 0, 1 = one parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  reset, asynchronous, active-low
tick_i  input  1  single-cycle oversampling strobe, 16 per bit period
rx_i  input  1  asynchronous serial line, idle high
data_o  output  DATA_BITS  received word, stable while valid_o = 1
valid_o  output  1  word available in the holding register
ready_i  input  1  consumer accepts the word when valid_o && ready_i
frame_err_o  output  1  stop bit sampled low for the word in data_o
parity_err_o  output  1  parity mismatch for the word in data_o
overrun_o  output  1  one-cycle pulse when a completed word is dropped
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous on rst_n_i = 0: state IDLE, synchroniser FFs = 1, tick counter = 0.
- Reset values of outputs: data_o = 0, valid_o = 0, frame_err_o = 0, parity_err_o = 0, overrun_o = 0, busy_o = 0.
- Reset mid-frame abandons the frame; no partial word is ever delivered.
- rx_i passes through a 2-FF synchroniser (rx_s). All decisions use rx_s, so there are 2 cycles of latency.
- The tick counter (cnt, 4 bits, 0..15) advances only on tick_i. It wraps 15 -> 0 at each bit boundary.
- Samples are taken at cnt = 7, 8 and 9. The bit value is majority(s7, s8, s9), decided on the tick where cnt = 9.
- IDLE: on tick_i with rx_s = 0, go to START with cnt = 0.
- START: at the cnt = 9 decision, if the majority is 1 the start bit was a glitch: go to IDLE, no output. Otherwise continue; at cnt = 15 go to DATA with bit index 0.
- DATA: at cnt = 9, shift the majority bit into the MSB of the shift register (LSB-first assembly). At cnt = 15, increment the index. After bit DATA_BITS-1, go to PARITY if PARITY_EN = 1, else STOP.
- PARITY: at cnt = 9, the computed error is XOR(data bits, parity bit) XOR PARITY_ODD != 0. At cnt = 15, go to STOP.
- STOP: at cnt = 9, complete the frame. Deliver the word with frame_err = !majority. Next state is IDLE if the majority is 1; otherwise WAIT_HIGH.
- Returning to IDLE at mid-stop-bit, before the bit ends, is intentional: it absorbs baud mismatch.
- WAIT_HIGH (break or line stuck low): remain here until rx_s = 1, then go to IDLE. No start detection happens in this state.
- Delivery happens on the completion cycle:
  - If valid_o = 0, or valid_o && ready_i on that same cycle: load data_o and both error flags, set valid_o = 1.
  - Else (valid_o && !ready_i): drop the new word, keep the old word and its flags, pulse overrun_o for 1 cycle.
- A handshake (valid_o && ready_i) with no simultaneous completion clears valid_o on the next edge. data_o holds its value; the error flags are not required to clear.
- The error flags are only meaningful while valid_o = 1.
- rate_i changes in the tick generator are the system's responsibility and must occur only while busy_o = 0. The receiver does not detect a rate change.

Decomposition:
- Package uart_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}
  - localparam OVERSAMPLE = 16
  - localparams SAMPLE_A = 7, SAMPLE_B = 8, SAMPLE_C = 9, LAST_TICK = 15
- One sub-module: uart_sync2, a generic 2-FF synchroniser with reset value 1. It is reused by other asynchronous inputs.

Test Plan:
- Rate 0, 8N1: send 0xA5 with ready_i = 1. Required: valid_o pulses 1 cycle, data_o = 0xA5, frame_err_o = 0, parity_err_o = 0, busy_o = 0 after mid-stop.
- Glitch: rx_i low for 5 ticks, then high. Required: no valid_o, state returns to IDLE, then a following 0x3C frame is received correctly.
- Noise: in frame 0x00, force rx_i high during only the cnt = 8 sample of bit 3. Required: data_o = 0x00 (majority wins).
- PARITY_EN = 1, PARITY_ODD = 0: send 0x07 with parity bit 1 -> parity_err_o = 0. Send 0x07 with parity bit 0 -> parity_err_o = 1.
- Framing and break:
  - 0x55 with stop low: data_o = 0x55, frame_err_o = 1, busy_o stays high in WAIT_HIGH until rx_i returns high.
  - 20-bit break: exactly one word, 0x00 with frame_err_o = 1.
- Overrun and reset:
  - ready_i = 0, send 0x11 then 0x22: data_o = 0x11, overrun_o pulses once.
  - Assert rst_n_i mid-DATA: all outputs are 0 immediately, and the next frame is received cleanly.
